cc_cmd_dispatch: RTL

CC_CMD_DISPATCH -- requirements
Module: cc_cmd_dispatch

---
 rtl/cc_defs.sv | 49 ++++
 rtl/cc_watchdog.sv | 36 +++
 rtl/cc_cmd_dispatch.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/cc_defs.sv
// ----------------------------------------------------------------------------
// cc_defs: shared command-code width, dispatcher defaults and state indices.
// rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package cc_defs;

   localparam int CC_W         = 5;
   localparam int NUM_CMDS_DEF = 16;

   localparam int S_IDLE      = 0;
   localparam int S_WAIT_CSN  = 1;
   localparam int S_LATCH_CSN = 2;
   localparam int S_WAIT_CC   = 3;
   localparam int S_LATCH_CC  = 4;
   localparam int S_DECODE    = 5;
   localparam int S_RUN       = 6;
   localparam int S_DRAIN     = 7;
   localparam int S_ERR_CSN1  = 8;
   localparam int S_ERR_CSN2  = 9;
   localparam int S_ERR_CC1   = 10;
   localparam int S_ERR_CC2   = 11;
   localparam int S_DONE      = 12;
   localparam int N_STATES    = 13;

   typedef enum logic [N_STATES-1:0] {
      ST_IDLE      = 13'b1 << S_IDLE,
      ST_WAIT_CSN  = 13'b1 << S_WAIT_CSN,
      ST_LATCH_CSN = 13'b1 << S_LATCH_CSN,
      ST_WAIT_CC   = 13'b1 << S_WAIT_CC,
      ST_LATCH_CC  = 13'b1 << S_LATCH_CC,
      ST_DECODE    = 13'b1 << S_DECODE,
      ST_RUN       = 13'b1 << S_RUN,
      ST_DRAIN     = 13'b1 << S_DRAIN,
      ST_ERR_CSN1  = 13'b1 << S_ERR_CSN1,
      ST_ERR_CSN2  = 13'b1 << S_ERR_CSN2,
      ST_ERR_CC1   = 13'b1 << S_ERR_CC1,
      ST_ERR_CC2   = 13'b1 << S_ERR_CC2,
      ST_DONE      = 13'b1 << S_DONE
   } state_t;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/cc_watchdog.sv
// ----------------------------------------------------------------------------
// cc_watchdog: counts enabled cycles; expired flags the last allowed cycle.
// rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module cc_watchdog #(
   parameter int TIMEOUT = 65535
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

   logic [CW-1:0] count;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && (count != CW'(TIMEOUT))) begin
         count <= count + CW'(1);
      end
   end

   // Asserted during the TIMEOUT-th enabled cycle so the owner leaves on that edge.
   assign expired = enable && (count == CW'(TIMEOUT - 1));

endmodule

`default_nettype wire

// File: rtl/cc_cmd_dispatch.sv
// ----------------------------------------------------------------------------
// cc_cmd_dispatch: reads CSN/CC from RX, runs one command SM or sends an error.
// rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module cc_cmd_dispatch
   import cc_defs::*;
#(
   parameter int NUM_CMDS = NUM_CMDS_DEF,
   parameter int TIMEOUT  = 65535
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                rx_tvalid,
   input  logic [31:0]         rx_data,
   input  logic                rx_tlast,
   output logic                rx_tready,
   input  logic                tx_tready,
   output logic                tx_tvalid,
   output logic                tx_tlast,
   output logic                send_csn,
   output logic                send_inv_cmd,
   output logic [31:0]         csn,
   output logic [CC_W-1:0]     cc,
   output logic [NUM_CMDS-1:0] run_sm,
   input  logic [NUM_CMDS-1:0] sm_done,
   output logic [15:0]         err_count,
   output logic                busy
);

   state_t state;
   logic   cc_last;
   logic   err_flag;
   logic   cc_legal;
   logic   sel_done;
   logic   wd_clear;
   logic   wd_enable;
   logic   wd_expired;

   assign cc_legal  = int'(cc) < NUM_CMDS;
   assign wd_enable = state[S_RUN];
   assign wd_clear  = ~state[S_RUN];

   always_comb begin
      sel_done = 1'b0;
      for (int i = 0; i < NUM_CMDS; i++) begin
         if (cc == CC_W'(i)) sel_done = sm_done[i];
      end
   end

   always_comb begin
      run_sm = '0;
      for (int i = 0; i < NUM_CMDS; i++) begin
         run_sm[i] = state[S_RUN] && (cc == CC_W'(i));
      end
   end

   cc_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clk     (clk),
      .reset   (reset),
      .clear   (wd_clear),
      .enable  (wd_enable),
      .expired (wd_expired)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= ST_IDLE;
         csn       <= '0;
         cc        <= '0;
         cc_last   <= 1'b0;
         err_flag  <= 1'b0;
         err_count <= '0;
      end else begin
         unique case (1'b1)
            state[S_IDLE]:     state <= ST_WAIT_CSN;
            state[S_WAIT_CSN]: if (rx_tvalid) state <= ST_LATCH_CSN;
            state[S_LATCH_CSN]: begin
               csn <= rx_data;
               if (rx_tlast) begin
                  err_flag <= 1'b1;
                  state    <= ST_ERR_CSN1;
               end else begin
                  state <= ST_WAIT_CC;
               end
            end
            state[S_WAIT_CC]:  if (rx_tvalid) state <= ST_LATCH_CC;
            state[S_LATCH_CC]: begin
               cc      <= rx_data[CC_W-1:0];
               cc_last <= rx_tlast;
               state   <= ST_DECODE;
            end
            // A legal code with tlast still runs: the command SM flags it itself.
            state[S_DECODE]: begin
               if (cc_legal) begin
                  state <= ST_RUN;
               end else begin
                  err_flag <= 1'b1;
                  state    <= cc_last ? ST_ERR_CSN1 : ST_DRAIN;
               end
            end
            state[S_RUN]: begin
               if (sel_done) begin
                  state <= ST_DONE;
               end else if (wd_expired) begin
                  err_count <= sat_inc16(err_count);
                  state     <= ST_DONE;
               end
            end
            state[S_DRAIN]:    if (rx_tvalid && rx_tlast) state <= ST_ERR_CSN1;
            state[S_ERR_CSN1]: if (tx_tready) state <= ST_ERR_CSN2;
            state[S_ERR_CSN2]: state <= ST_ERR_CC1;
            state[S_ERR_CC1]:  if (tx_tready) state <= ST_ERR_CC2;
            state[S_ERR_CC2]: begin
               if (err_flag) err_count <= sat_inc16(err_count);
               state <= ST_DONE;
            end
            state[S_DONE]: begin
               err_flag <= 1'b0;
               state    <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Outputs are direct decodes of one-hot state flops.
   assign rx_tready    = state[S_LATCH_CSN] | state[S_LATCH_CC] | (state[S_DRAIN] & rx_tvalid);
   assign tx_tvalid    = state[S_ERR_CSN2] | state[S_ERR_CC2];
   assign tx_tlast     = state[S_ERR_CC2];
   assign send_csn     = state[S_ERR_CSN1] | state[S_ERR_CSN2];
   assign send_inv_cmd = state[S_ERR_CC1] | state[S_ERR_CC2];
   assign busy         = ~state[S_IDLE];

endmodule

`default_nettype wire
